// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    BYTE,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int LANE_W     = 8;
  localparam int LANES      = 4;
  localparam int WORD_W     = LANE_W * LANES;
  localparam int LANE_CNT_W = $clog2(LANES);
  localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(LANES - 1);

  localparam int COUNT_W           = 16;
  localparam int DEFAULT_MAX_WORDS = 256;
  localparam int IDX_W             = $clog2(DEFAULT_MAX_WORDS);

  // Word-index width for a given word limit; never narrower than one bit.
  function automatic int idx_width(input int max_words);
    return (max_words > 1) ? $clog2(max_words) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  import imem_loader_pkg::*;

  logic                in_valid;
  logic [LANE_W-1:0]   in_data;
  logic                in_ready;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [WORD_W-1:0]   imem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_load_shifter.sv
// Big-endian 4-byte word assembler: first byte lands in the top lane.
module imem_load_shifter
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [LANE_W-1:0] lane_data,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [LANE_CNT_W-1:0] lane_cnt;

  // clear only rewinds the lane counter; a full word always overwrites every lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      lane_cnt <= '0;
    end else if (clear) begin
      lane_cnt <= '0;
    end else if (load) begin
      word     <= {word[WORD_W-LANE_W-1:0], lane_data};
      lane_cnt <= lane_cnt + 1'b1;
    end
  end

  assign word_full = load && !clear && (lane_cnt == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream into words, writes instruction memory,
// and holds the core in stall until the whole image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                MAX_WORDS      = DEFAULT_MAX_WORDS,
  parameter int                TIMEOUT_CYCLES = 1024
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          done,
  output logic          error
);

  localparam int WIDX_W = idx_width(MAX_WORDS);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [COUNT_W-1:0]   count_q;
  logic [COUNT_W-1:0]   count_next;
  logic [COUNT_W-1:0]   len_word;
  logic [WIDX_W-1:0]    word_idx;
  logic [WIDX_W-1:0]    word_idx_next;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 accept;
  logic                 counting;
  logic                 timed_out;
  logic                 last_word;
  logic                 shift_load;
  logic                 shift_clear;
  logic                 word_full;
  logic [WORD_W-1:0]    word;

  assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == BYTE);
  assign accept       = bus.in_valid && bus.in_ready;

  // The idle counter only runs while waiting for length-low or payload bytes.
  assign counting  = (state == LEN_LO) || (state == BYTE);
  assign timed_out = counting && !accept && (idle_cnt == IDLE_LIMIT);
  assign last_word = (COUNT_W'(word_idx) == (count_q - 16'd1));

  imem_load_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shift_load),
    .clear     (shift_clear),
    .lane_data (bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= '0;
      word_idx <= '0;
    end else begin
      state    <= state_next;
      count_q  <= count_next;
      word_idx <= word_idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!counting || accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count_q;
    word_idx_next = word_idx;
    shift_load    = 1'b0;
    shift_clear   = 1'b0;
    len_word      = {count_q[15:8], bus.in_data};
    case (state)
      IDLE: begin
        if (start) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          count_next[15:8] = bus.in_data;
          state_next       = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          count_next    = len_word;
          word_idx_next = '0;
          shift_clear   = 1'b1;
          if (len_word == '0) begin
            state_next = DONE;
          end else if ({16'd0, len_word} > 32'(MAX_WORDS)) begin
            state_next = ERR;
          end else begin
            state_next = BYTE;
          end
        end else if (timed_out) begin
          state_next = ERR;
        end
      end
      BYTE: begin
        shift_load = accept;
        if (word_full) begin
          state_next = WRITE;
        end else if (timed_out) begin
          shift_clear = 1'b1;
          state_next  = ERR;
        end
      end
      WRITE: begin
        if (last_word) begin
          state_next = DONE;
        end else begin
          word_idx_next = word_idx + 1'b1;
          state_next    = BYTE;
        end
      end
      DONE, ERR: begin
        if (start) state_next = LEN_HI;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address wraps modulo 2^ADDR_W by construction of the adder width.
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = BASE_ADDR + (ADDR_W'(word_idx) << 2);
  assign bus.imem_wdata = word;

  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign core_hold = (state != DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader and the write side of the pipeline's instruction memory. It accepts a byte stream on a valid/ready interface, frames it as a 16-bit word count followed by big-endian 32-bit instructions, and writes each word into instruction memory. It holds the pipeline (fetch PC and stage registers) stalled until the image is fully written, then releases it. It sits beside the fetch stage and drives the instruction-memory write port that fetch only reads.

Parameters:
ADDR_W, 32, width of the instruction-memory byte address
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be a multiple of 4
MAX_WORDS, 256, largest legal word count; a larger count is an error
TIMEOUT_CYCLES, 1024, idle cycles allowed between accepted bytes once a load has begun

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a load from IDLE, DONE or ERR
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader accepts in_data this cycle
imem_we  out  1  instruction-memory write strobe, one cycle per word
imem_addr  out  ADDR_W  byte address of the word being written
imem_wdata  out  32  instruction word
core_hold  out  1  stalls the fetch PC and pipeline registers while high
done  out  1  image loaded; level output
error  out  1  load aborted; level output, sticky

Behaviour:
- Reset (async assert, sync release): state IDLE, core_hold=1, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, error=0, all counters 0.
- A byte is accepted only when in_valid && in_ready at a clk edge. Bytes offered while in_ready=0 are neither consumed nor dropped.
- State IDLE: in_ready=0. On start, go to LEN_HI.
- State LEN_HI: in_ready=1. The accepted byte becomes count[15:8]. Go to LEN_LO. No timeout applies in this state.
- State LEN_LO: in_ready=1. The accepted byte becomes count[7:0].
  - If count==0, go to DONE.
  - If count>MAX_WORDS, go to ERR.
  - Otherwise go to BYTE with byte index 0 and word index 0.
- State BYTE: in_ready=1. Each accepted byte shifts into the word register, first byte in [31:24]. When the 4th byte is accepted, go to WRITE.
- State WRITE: in_ready=0. imem_we=1 for exactly one cycle, with imem_addr=BASE_ADDR+4*word_index and imem_wdata=the assembled word.
  - Latency: the 4th byte is accepted at edge t, and imem_we is high during cycle t+1.
  - Next state is DONE if word_index==count-1; otherwise word_index increments and the next state is BYTE.
- State DONE: done=1, core_hold=0, in_ready=0.
- State ERR: error=1, core_hold=1, in_ready=0, and no further writes occur.
- Leaving DONE or ERR on start: done and error clear, core_hold returns to 1, and the next state is LEN_HI.
- start is ignored in every other state.
- Timeout: an idle counter clears on every accepted byte and whenever the state is not LEN_LO or BYTE. It increments each cycle in LEN_LO or BYTE with no byte accepted. When it reaches TIMEOUT_CYCLES, go to ERR. Any partial word is discarded.
- Word index width is clog2(MAX_WORDS). The address is computed modulo 2^ADDR_W with no overflow check.
- Reset asserted mid-load aborts immediately to the reset values above. Already-written words remain in memory.
- core_hold is 0 only in DONE.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, BYTE, WRITE, DONE, ERR);
  - the byte-lane constants;
  - the localparam for index width.
- One sub-module, imem_load_shifter: a 4-byte big-endian assembler with load/clear inputs, a 2-bit byte counter, and a word_full output.
- The FSM, the timeout counter and address generation stay in imem_loader.

Test Plan:
- Stream 00 02 | 8C 01 00 04 | 00 22 18 20 with in_valid held high:
  - two imem_we pulses: addr BASE+0 data 8C010004, then BASE+4 data 00221820;
  - done=1 and core_hold=0 on the cycle after the second write.
- Stream 00 00 -> DONE directly, no imem_we pulses, core_hold=0.
- Count 01 01 (257) with MAX_WORDS=256 -> error=1, core_hold=1, no writes, in_ready=0.
- One word with 3-cycle gaps between bytes (in_valid low) -> the same single write as back-to-back bytes; idle counter never exceeds 3.
- Valid drops after 2 data bytes for TIMEOUT_CYCLES cycles -> ERR, no write. A following start plus a good 1-word stream -> the write lands at BASE+0 and done=1.
- Reset pulsed while in BYTE -> all outputs return to reset values asynchronously; load resumes only after start.
